// File: rtl/vga_pkg.sv
// Shared definitions for the debug-overlay refresh path: FSM encoding,
// default geometry and the glyph ROM address layout.
package vga_pkg;

    localparam int DEF_NUM_SEQ    = 16;
    localparam int DEF_SEQ_DIGITS = 4;
    localparam int DEF_FONT_WIDTH = 8;

    localparam int NIB_W       = 4;
    localparam int ROW_W       = 3;
    localparam int FONT_ADDR_W = NIB_W + ROW_W;
    localparam int SEQ_W       = 4;
    localparam int DIG_W       = 2;

    localparam logic [ROW_W-1:0] LAST_ROW = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNAP  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DRAIN = 2'd3
    } refresh_state_e;

    // Glyph ROM address: hex nibble selects the glyph, row selects the line.
    typedef struct packed {
        logic [NIB_W-1:0] nib;
        logic [ROW_W-1:0] row;
    } font_addr_t;

endpackage

// File: rtl/refresh_addr_counter.sv
// Nested row/digit/seq counter walking every glyph row of every digit.
// Row wraps fastest, then digit, then seq; last_o flags the final address.
module refresh_addr_counter
    import vga_pkg::*;
#(
    parameter int NUM_SEQ    = DEF_NUM_SEQ,
    parameter int SEQ_DIGITS = DEF_SEQ_DIGITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             adv_i,
    output logic [ROW_W-1:0] row_o,
    output logic [DIG_W-1:0] digit_o,
    output logic [SEQ_W-1:0] seq_o,
    output logic             last_o
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             row_end, dig_end, seq_end;

    assign row_end = (row_q == LAST_ROW);
    assign dig_end = (dig_q == DIG_W'(SEQ_DIGITS - 1));
    assign seq_end = (seq_q == SEQ_W'(NUM_SEQ - 1));

    // Next count: clear wins over advance; each level carries into the next.
    always_comb begin
        row_d = row_q;
        dig_d = dig_q;
        seq_d = seq_q;
        if (clr_i) begin
            row_d = '0;
            dig_d = '0;
            seq_d = '0;
        end else if (adv_i) begin
            if (row_end) begin
                row_d = '0;
                if (dig_end) begin
                    dig_d = '0;
                    seq_d = seq_end ? '0 : seq_q + 1'b1;
                end else begin
                    dig_d = dig_q + 1'b1;
                end
            end else begin
                row_d = row_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_q <= '0;
            dig_q <= '0;
            seq_q <= '0;
        end else begin
            row_q <= row_d;
            dig_q <= dig_d;
            seq_q <= seq_d;
        end
    end

    assign row_o   = row_q;
    assign digit_o = dig_q;
    assign seq_o   = seq_q;
    assign last_o  = row_end & dig_end & seq_end;

endmodule

// File: rtl/debug_refresh_ctrl.sv
// Debug overlay refresh: on frame start, snapshot the debug values and
// stream every glyph row of every digit through the shared font ROM into
// the debug pixel buffers, one row per cycle.
module debug_refresh_ctrl
    import vga_pkg::*;
#(
    parameter int NUM_SEQ    = DEF_NUM_SEQ,
    parameter int SEQ_DIGITS = DEF_SEQ_DIGITS,
    parameter int FONT_WIDTH = DEF_FONT_WIDTH
) (
    input  logic                                sys_clk,
    input  logic                                sys_rst,
    input  logic                                enable,
    input  logic                                frame_start,
    input  logic [NUM_SEQ*SEQ_DIGITS*NIB_W-1:0] debug_vals,
    output logic [FONT_ADDR_W-1:0]              font_addr,
    input  logic [FONT_WIDTH-1:0]               font_data,
    output logic                                wr_en,
    output logic [SEQ_W-1:0]                    wr_seq,
    output logic [DIG_W-1:0]                    wr_digit,
    output logic [ROW_W-1:0]                    wr_row,
    output logic [FONT_WIDTH-1:0]               wr_bits,
    output logic                                busy,
    output logic                                done,
    output logic                                overrun
);

    localparam int VALS_W = NUM_SEQ * SEQ_DIGITS * NIB_W;

    refresh_state_e   state_q, state_d;
    logic [VALS_W-1:0] snap_q;
    logic [VALS_W-1:0] snap_sh;
    logic             overrun_q;
    logic             wr_en_q;
    logic [SEQ_W-1:0] wr_seq_q;
    logic [DIG_W-1:0] wr_dig_q;
    logic [ROW_W-1:0] wr_row_q;

    logic [ROW_W-1:0] cnt_row;
    logic [DIG_W-1:0] cnt_dig;
    logic [SEQ_W-1:0] cnt_seq;
    logic             cnt_last;
    logic             fetching;
    font_addr_t       fa;

    assign fetching = (state_q == ST_FETCH);

    refresh_addr_counter #(
        .NUM_SEQ    (NUM_SEQ),
        .SEQ_DIGITS (SEQ_DIGITS)
    ) u_cnt (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .clr_i   (state_q == ST_SNAP),
        .adv_i   (fetching),
        .row_o   (cnt_row),
        .digit_o (cnt_dig),
        .seq_o   (cnt_seq),
        .last_o  (cnt_last)
    );

    // Next state: a sweep is SNAP, then one FETCH per glyph row, then DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (frame_start && enable) state_d = ST_SNAP;
            ST_SNAP:  state_d = ST_FETCH;
            ST_FETCH: if (cnt_last) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Snapshot of debug values, frozen for the whole sweep.
    always_ff @(posedge sys_clk) begin
        if (sys_rst)                 snap_q <= '0;
        else if (state_q == ST_SNAP) snap_q <= debug_vals;
    end

    // Glyph address from the snapshot nibble at the current (seq, digit).
    always_comb begin
        snap_sh = snap_q >> ((int'(cnt_seq) * SEQ_DIGITS + int'(cnt_dig)) * NIB_W);
        fa.nib  = snap_sh[NIB_W-1:0];
        fa.row  = cnt_row;
    end

    assign font_addr = fetching ? fa : '0;

    // Write pipeline: the ROM answers one cycle after the address, so the
    // target coordinates trail the issued address by one register stage.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_en_q  <= 1'b0;
            wr_seq_q <= '0;
            wr_dig_q <= '0;
            wr_row_q <= '0;
        end else begin
            wr_en_q <= fetching;
            if (fetching) begin
                wr_seq_q <= cnt_seq;
                wr_dig_q <= cnt_dig;
                wr_row_q <= cnt_row;
            end
        end
    end

    // Sticky flag: a frame started before the previous sweep finished.
    always_ff @(posedge sys_clk) begin
        if (sys_rst)                  overrun_q <= 1'b0;
        else if (frame_start && busy) overrun_q <= 1'b1;
    end

    assign wr_en    = wr_en_q;
    assign wr_seq   = wr_seq_q;
    assign wr_digit = wr_dig_q;
    assign wr_row   = wr_row_q;
    assign wr_bits  = wr_en_q ? font_data : '0;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DRAIN);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_debug_refresh_ctrl.sv
// Scoreboard bench for debug_refresh_ctrl: each sweep pushes its 512
// expected writes; a negedge monitor pops and compares every wr_en.
module tb_debug_refresh_ctrl;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic         enable = 1'b0;
    logic         frame_start = 1'b0;
    logic [255:0] debug_vals = '0;
    logic [6:0]   font_addr;
    logic [7:0]   font_data = '0;
    logic         wr_en;
    logic [3:0]   wr_seq;
    logic [1:0]   wr_digit;
    logic [2:0]   wr_row;
    logic [7:0]   wr_bits;
    logic         busy, done, overrun;

    typedef struct {
        logic [3:0] seq;
        logic [1:0] dig;
        logic [2:0] row;
        logic [7:0] bits;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0, n_fail = 0;
    int   wr_cnt = 0, busy_cnt = 0, done_cnt = 0;

    debug_refresh_ctrl dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .enable      (enable),
        .frame_start (frame_start),
        .debug_vals  (debug_vals),
        .font_addr   (font_addr),
        .font_data   (font_data),
        .wr_en       (wr_en),
        .wr_seq      (wr_seq),
        .wr_digit    (wr_digit),
        .wr_row      (wr_row),
        .wr_bits     (wr_bits),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    // Injective model glyph ROM: the returned bits identify the address.
    function automatic logic [7:0] rom(input logic [6:0] a);
        return {a, 1'b0} ^ 8'h5B;
    endfunction

    always @(posedge sys_clk) font_data <= rom(font_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: count activity, compare each write against the scoreboard.
    always @(negedge sys_clk) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (!busy) check("addr_idle", 32'(font_addr), 0);
        if (done) begin
            done_cnt++;
            check("done_with_wr", 32'(wr_en), 1);
            check("done_last_entry", sb_q.size(), 1);
        end
        if (wr_en) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                check("wr_unexpected", 32'(wr_en), 0);
            end else begin
                e = sb_q.pop_front();
                check("wr_seq",   32'(wr_seq),   32'(e.seq));
                check("wr_digit", 32'(wr_digit), 32'(e.dig));
                check("wr_row",   32'(wr_row),   32'(e.row));
                check("wr_bits",  32'(wr_bits),  32'(e.bits));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    32'(busy), 0);
        check({tag, "_done"},    32'(done), 0);
        check({tag, "_overrun"}, 32'(overrun), 0);
        check({tag, "_wr_en"},   32'(wr_en), 0);
        check({tag, "_addr"},    32'(font_addr), 0);
        check({tag, "_wr_seq"},  32'(wr_seq), 0);
        check({tag, "_wr_dig"},  32'(wr_digit), 0);
        check({tag, "_wr_row"},  32'(wr_row), 0);
        check({tag, "_wr_bits"}, 32'(wr_bits), 0);
    endtask

    // Reset with a simultaneous enabled frame_start: reset must win.
    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1; frame_start = 1'b1; enable = 1'b1;
        @(negedge sys_clk);
        frame_start = 1'b0; enable = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        sb_q.delete();
        @(negedge sys_clk);
        check_reset_outputs("rst");
    endtask

    task automatic push_sweep(input logic [255:0] v);
        exp_t e;
        logic [3:0] nib;
        for (int s = 0; s < 16; s++)
            for (int d = 0; d < 4; d++)
                for (int r = 0; r < 8; r++) begin
                    nib    = v[(s*4+d)*4 +: 4];
                    e.seq  = 4'(s);
                    e.dig  = 2'(d);
                    e.row  = 3'(r);
                    e.bits = rom({nib, 3'(r)});
                    sb_q.push_back(e);
                end
    endtask

    // Called at a negedge with the DUT idle.
    task automatic start_sweep(input logic [255:0] v);
        debug_vals = v;
        enable = 1'b1;
        wr_cnt = 0; busy_cnt = 0; done_cnt = 0;
        push_sweep(v);
        frame_start = 1'b1;
        @(negedge sys_clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done && t < 1000) begin
            @(negedge sys_clk);
            t++;
        end
        check({tag, "_timeout"}, 32'(t < 1000), 1);
        tick(2);
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_wr_count"},   wr_cnt, 512);
        check({tag, "_busy_count"}, busy_cnt, 514);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_sb_empty"},   sb_q.size(), 0);
    endtask

    function automatic logic [255:0] rand_vals();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [255:0] v;
        int k, t;

        do_reset();

        // All-zero values: every glyph address uses nibble 0.
        start_sweep('0);
        wait_done("zero");
        end_checks("zero");

        // Sequence 3 = A5C1, digit 0 leftmost; enable dropped mid-sweep.
        v = rand_vals();
        v[63:48] = {4'h1, 4'hC, 4'h5, 4'hA};
        start_sweep(v);
        tick(5);
        enable = 1'b0;
        wait_done("seq3");
        end_checks("seq3");

        // debug_vals changed after SNAP must not leak into the sweep.
        v = rand_vals();
        start_sweep(v);
        tick(10);
        debug_vals = ~v;
        wait_done("snap");
        end_checks("snap");

        // Second frame_start mid-sweep: ignored, overrun set and sticky.
        start_sweep(rand_vals());
        tick(100);
        frame_start = 1'b1;
        @(negedge sys_clk);
        frame_start = 1'b0;
        check("ovr_set", 32'(overrun), 1);
        wait_done("ovr");
        end_checks("ovr");
        tick(20);
        check("ovr_sticky", 32'(overrun), 1);
        do_reset();

        // Reset at write 200 aborts the sweep.
        start_sweep(rand_vals());
        k = 0; t = 0;
        while (k < 200 && t < 1000) begin
            @(negedge sys_clk);
            t++;
            if (wr_en) k++;
        end
        check("abort_reach_200", 32'(t < 1000), 1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check_reset_outputs("abort");
        sys_rst = 1'b0;
        sb_q.delete();
        @(negedge sys_clk);
        check("abort_wr_en_next", 32'(wr_en), 0);
        check("abort_busy_next",  32'(busy), 0);
        start_sweep(rand_vals());
        wait_done("post_abort");
        end_checks("post_abort");

        // frame_start with enable low does nothing.
        enable = 1'b0;
        wr_cnt = 0; busy_cnt = 0; done_cnt = 0;
        frame_start = 1'b1;
        @(negedge sys_clk);
        frame_start = 1'b0;
        tick(20);
        check("dis_busy_count", busy_cnt, 0);
        check("dis_wr_count",   wr_cnt, 0);
        check("dis_overrun",    32'(overrun), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_refresh_ctrl.md
DEBUG_REFRESH_CTRL -- requirements
Module: debug_refresh_ctrl

Interface
REQ-001 SHALL have parameter NUM_SEQ, default 16, number of debug sequence rows.
REQ-002 SHALL have parameter SEQ_DIGITS, default 4, hex digits per sequence.
REQ-003 SHALL have parameter FONT_WIDTH, default 8, glyph width and height in pixels.
REQ-004 SHALL have port sys_clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port sys_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port enable  input  1  when low, frame_start is ignored.
REQ-007 SHALL have port frame_start  input  1  one-cycle pulse at the start of vertical blank.
REQ-008 SHALL have port debug_vals  input  NUM_SEQ*SEQ_DIGITS*4  packed nibbles; seq s, digit d at bits [(s*SEQ_DIGITS+d)*4 +: 4], digit 0 leftmost.
REQ-009 SHALL have port font_addr  output  7  {nibble[3:0], row[2:0]} to the shared glyph ROM.
REQ-010 SHALL have port font_data  input  FONT_WIDTH  glyph row bits, valid exactly 1 cycle after font_addr; bit 7 = leftmost pixel.
REQ-011 SHALL have port wr_en  output  1  write strobe to the debug pixel buffers.
REQ-012 SHALL have port wr_seq  output  4  target sequence index.
REQ-013 SHALL have port wr_digit  output  2  target digit index.
REQ-014 SHALL have port wr_row  output  3  target glyph row.
REQ-015 SHALL have port wr_bits  output  FONT_WIDTH  glyph row bits (equal to font_data).
REQ-016 SHALL have port busy  output  1  high from SNAP through DRAIN.
REQ-017 SHALL have port done  output  1  one-cycle pulse when a full sweep completes.
REQ-018 SHALL have port overrun  output  1  sticky; set when frame_start arrives while busy.

Function
REQ-019 SHALL implement FSM states IDLE, SNAP, FETCH, DRAIN.
REQ-020 SHALL move IDLE->SNAP on frame_start && enable; other IDLE cycles stay IDLE.
REQ-021 SHALL in SNAP register debug_vals into an internal snapshot and clear seq/digit/row counters; SNAP lasts exactly 1 cycle, then FETCH.
REQ-022 SHALL in FETCH drive font_addr from snapshot nibble (seq,digit) and row each cycle, incrementing row fastest, then digit, then seq.
REQ-023 SHALL enter DRAIN after issuing the address for seq=NUM_SEQ-1, digit=SEQ_DIGITS-1, row=7; DRAIN lasts 1 cycle, then IDLE.
REQ-024 SHALL assert wr_en, with wr_seq/wr_digit/wr_row delayed by one cycle from the issued address, in the cycle font_data is valid (write latency 1 cycle after address).
REQ-025 SHALL issue exactly NUM_SEQ*SEQ_DIGITS*8 reads and writes per sweep (512 at defaults), with no gaps; sweep length = 1 + 512 + 1 cycles from SNAP.
REQ-026 SHALL pulse done in the DRAIN cycle, concurrently with the final wr_en.
REQ-027 SHALL ignore frame_start while busy, and set overrun in the following cycle.
REQ-028 SHALL use only the snapshot during a sweep; debug_vals changes after SNAP have no effect until the next sweep.
REQ-029 SHALL let enable going low mid-sweep have no effect; the current sweep completes.
REQ-030 SHALL hold font_addr at 0 and wr_en at 0 outside FETCH/DRAIN.

Reset
REQ-031 SHALL, with sys_rst high at a clock edge, force state IDLE, counters 0, snapshot 0, font_addr 0, wr_en 0, wr_seq/wr_digit/wr_row/wr_bits 0, busy 0, done 0, overrun 0.
REQ-032 SHALL abort any sweep when reset occurs mid-operation, with no write issued in the reset cycle or the following cycle.
REQ-033 SHALL give sys_rst priority over frame_start in the same cycle.

Structure
REQ-034 SHALL take FSM state encoding, NUM_SEQ/SEQ_DIGITS/FONT_WIDTH defaults and the font_addr field layout from shared package vga_pkg.
REQ-035 SHALL use one sub-module: refresh_addr_counter (row/digit/seq nested counter with a last flag); the FSM and write pipeline stay in the top level.

Verification
REQ-036 SHALL cover: reset, then frame_start with enable=1 and debug_vals all 0x0 -> busy for 514 cycles, 512 wr_en, done once, all font_addr nibbles 0.
REQ-037 SHALL cover: seq 3 = 0xA5C1 -> writes for wr_seq=3 at digit 0..3 use font_addr nibbles A,5,C,1, rows 0..7 in order, wr_bits equal to the model ROM output.
REQ-038 SHALL cover: debug_vals changed 10 cycles after SNAP -> all 512 writes reflect the old value.
REQ-039 SHALL cover: a second frame_start 100 cycles into a sweep -> sweep unaffected, overrun=1 and it stays 1 until sys_rst.
REQ-040 SHALL cover: sys_rst asserted at write 200 -> wr_en=0 next cycle, state IDLE, all outputs at reset values; the next frame_start gives a full 512-write sweep.
REQ-041 SHALL cover: frame_start with enable=0 -> no busy, no writes, overrun stays 0.
